// File: rtl/branch_ctrl_if.sv
// rtl/branch_ctrl_if.sv - ID-stage branch control bus (ID operands, EX/MEM writeback tags, branch outputs)
interface branch_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic             id_branch;
  logic             id_link;
  logic             id_uses_rt;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             ex_wreg;
  logic [4:0]       ex_wa;
  logic             ex_load;
  logic             mem_wreg;
  logic [4:0]       mem_wa;
  logic             mem_load;
  logic             cmp_y;
  logic             br_stall;
  logic             br_redirect;
  logic             br_link;
  logic             ds_flag;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;

  // Pipeline side: presents the ID instruction and downstream writers.
  modport master (
    output id_valid, id_branch, id_link, id_uses_rt, id_rs, id_rt,
    output ex_wreg, ex_wa, ex_load, mem_wreg, mem_wa, mem_load, cmp_y,
    input  br_stall, br_redirect, br_link, ds_flag, branch_cnt, taken_cnt
  );

  // Branch controller side.
  modport slave (
    input  id_valid, id_branch, id_link, id_uses_rt, id_rs, id_rt,
    input  ex_wreg, ex_wa, ex_load, mem_wreg, mem_wa, mem_load, cmp_y,
    output br_stall, br_redirect, br_link, ds_flag, branch_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - ID-stage conditional branch sequencer: hazard stall, redirect, delay slot, statistics
module branch_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          pipe_stall,
  branch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DSLOT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_cnt;          // WAIT cycles still to spend after the current one
  logic [1:0]       w_cnt_nxt;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_taken_cnt;

  logic [1:0]       w_n_rs;
  logic [1:0]       w_n_rt;
  logic [1:0]       w_n;
  logic             w_is_br;
  logic             w_stall;
  logic             w_redirect;
  logic             w_link;
  logic             w_resolve;

  // Per-operand stall requirement; r0 is hardwired and MEM ALU results are forwarded.
  always_comb begin
    w_n_rs = 2'd0;
    w_n_rt = 2'd0;
    if (bus.id_rs != 5'd0) begin
      if (bus.ex_wreg && (bus.ex_wa == bus.id_rs))
        w_n_rs = bus.ex_load ? 2'd2 : 2'd1;
      else if (bus.mem_wreg && bus.mem_load && (bus.mem_wa == bus.id_rs))
        w_n_rs = 2'd1;
    end
    if (bus.id_uses_rt && (bus.id_rt != 5'd0)) begin
      if (bus.ex_wreg && (bus.ex_wa == bus.id_rt))
        w_n_rt = bus.ex_load ? 2'd2 : 2'd1;
      else if (bus.mem_wreg && bus.mem_load && (bus.mem_wa == bus.id_rt))
        w_n_rt = 2'd1;
    end
    w_n = (w_n_rs > w_n_rt) ? w_n_rs : w_n_rt;
  end

  // Next-state and output decode; flush overrides everything at the end.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_redirect  = 1'b0;
    w_link      = 1'b0;
    w_resolve   = 1'b0;
    w_is_br     = bus.id_valid && bus.id_branch;
    case (r_state)
      S_IDLE: begin
        if (w_is_br) begin
          if (w_n != 2'd0) begin
            // This cycle is the first stall cycle; a single-cycle hazard
            // needs no WAIT and is simply re-evaluated next cycle.
            w_stall = 1'b1;
            if (!pipe_stall) begin
              w_cnt_nxt   = w_n - 2'd1;
              w_state_nxt = (w_n == 2'd1) ? S_IDLE : S_WAIT;
            end
          end else if (!pipe_stall) begin
            w_resolve   = 1'b1;
            w_redirect  = bus.cmp_y;
            w_link      = bus.id_link;
            w_state_nxt = S_DSLOT;
          end
        end
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (!pipe_stall) begin
          if (r_cnt <= 2'd1) begin
            w_cnt_nxt   = 2'd0;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt - 2'd1;
          end
        end
      end
      S_DSLOT: begin
        // Whatever sits in the slot (even a branch) is passed through untouched.
        if (bus.id_valid && !pipe_stall)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) begin
      w_stall     = 1'b0;
      w_redirect  = 1'b0;
      w_link      = 1'b0;
      w_resolve   = 1'b0;
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 2'd0;
    end
  end

  // State and stall counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Saturating branch statistics, bumped only on an unstalled, unflushed resolve.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_branch_cnt <= '0;
      r_taken_cnt  <= '0;
    end else if (w_resolve) begin
      if (!(&r_branch_cnt))
        r_branch_cnt <= r_branch_cnt + 1'b1;
      if (bus.cmp_y && !(&r_taken_cnt))
        r_taken_cnt <= r_taken_cnt + 1'b1;
    end
  end

  assign bus.br_stall    = w_stall;
  assign bus.br_redirect = w_redirect;
  assign bus.br_link     = w_link;
  assign bus.ds_flag     = (r_state == S_DSLOT);
  assign bus.branch_cnt  = r_branch_cnt;
  assign bus.taken_cnt   = r_taken_cnt;

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - self-checking bench for branch_ctrl
module tb_branch_ctrl;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic resetn;
  logic flush;
  logic pipe_stall;

  always #5 clk = ~clk;

  branch_ctrl_if #(.CNT_W(CW)) bus ();

  branch_ctrl #(.CNT_W(CW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .pipe_stall (pipe_stall),
    .bus        (bus)
  );

  typedef struct {
    logic       v, br, lk, urt;
    logic [4:0] rs, rt;
    logic       exw;
    logic [4:0] exa;
    logic       exl;
    logic       mw;
    logic [4:0] ma;
    logic       ml;
    logic       cy, ps, fl;
    logic       e_stall, e_red, e_link, e_ds;
  } vec_t;

  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(input logic v, br, lk, urt, input logic [4:0] rs, rt,
                              input logic exw, input logic [4:0] exa, input logic exl,
                              input logic mw, input logic [4:0] ma, input logic ml,
                              input logic cy, ps, fl, input logic es, er, el, ed);
    vec_t x;
    x.v = v; x.br = br; x.lk = lk; x.urt = urt; x.rs = rs; x.rt = rt;
    x.exw = exw; x.exa = exa; x.exl = exl; x.mw = mw; x.ma = ma; x.ml = ml;
    x.cy = cy; x.ps = ps; x.fl = fl;
    x.e_stall = es; x.e_red = er; x.e_link = el; x.e_ds = ed;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t x);
    bus.id_valid   = x.v;   bus.id_branch = x.br;  bus.id_link  = x.lk;
    bus.id_uses_rt = x.urt; bus.id_rs     = x.rs;  bus.id_rt    = x.rt;
    bus.ex_wreg    = x.exw; bus.ex_wa     = x.exa; bus.ex_load  = x.exl;
    bus.mem_wreg   = x.mw;  bus.mem_wa    = x.ma;  bus.mem_load = x.ml;
    bus.cmp_y      = x.cy;  pipe_stall    = x.ps;  flush        = x.fl;
  endtask

  // Pipeline moves one step under a stall: EX result drops into MEM, bubble into EX.
  task automatic advance();
    bus.mem_wreg = bus.ex_wreg;
    bus.mem_wa   = bus.ex_wa;
    bus.mem_load = bus.ex_load;
    bus.ex_wreg  = 1'b0;
    bus.ex_wa    = 5'd0;
    bus.ex_load  = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    apply(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  // Counts br_stall cycles until the branch resolves; pipe_stall raised on loop iterations ps_from..ps_to.
  task automatic run_stall(input int ps_from, input int ps_to, output int nst, output logic redir);
    logic was;
    nst = 0;
    redir = 1'b0;
    for (int c = 0; c < 20; c++) begin
      pipe_stall = (c >= ps_from && c <= ps_to);
      @(negedge clk);
      if (!bus.br_stall && !pipe_stall) begin
        redir = bus.br_redirect;
        return;
      end
      was = bus.br_stall;
      if (was) nst++;
      @(posedge clk); #1;
      if (was && !pipe_stall) advance();
    end
    nst = 99;
  endtask

  vec_t tbl[15];
  vec_t z;

  initial begin
    int   nst;
    logic rd;
    int   wl, mb, mt, n, nr, nt;
    bit   mds, res;
    logic e_stall, e_red, e_lk, e_ds;
    vec_t r;

    z = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    resetn = 1'b0;
    apply(z);

    //            v br lk urt rs rt exw exa exl mw ma ml cy ps fl | stall red link ds
    tbl[0]  = mk(1,1,0,1, 3,4, 1,7,0, 1,8,1, 1,0,0, 0,1,0,1);
    tbl[1]  = mk(1,1,0,1, 5,9, 1,5,1, 0,0,0, 1,0,0, 1,0,0,0);
    tbl[2]  = mk(1,1,0,1, 5,9, 1,5,0, 0,0,0, 1,0,0, 1,0,0,0);
    tbl[3]  = mk(1,1,0,1, 2,6, 0,0,0, 1,6,1, 1,0,0, 1,0,0,0);
    tbl[4]  = mk(1,1,0,0, 2,6, 0,0,0, 1,6,1, 0,0,0, 0,0,0,1);
    tbl[5]  = mk(1,1,0,1, 5,9, 0,0,0, 1,5,0, 1,0,0, 0,1,0,1);
    tbl[6]  = mk(1,1,0,1, 0,0, 1,0,1, 1,0,1, 1,0,0, 0,1,0,1);
    tbl[7]  = mk(1,1,0,1, 5,9, 0,5,1, 0,0,0, 1,0,0, 0,1,0,1);
    tbl[8]  = mk(1,1,1,0, 3,0, 0,0,0, 0,0,0, 0,0,0, 0,0,1,1);
    tbl[9]  = mk(0,1,0,1, 5,9, 1,5,1, 0,0,0, 1,0,0, 0,0,0,0);
    tbl[10] = mk(1,0,0,1, 5,9, 1,5,1, 0,0,0, 1,0,0, 0,0,0,0);
    tbl[11] = mk(1,1,0,1, 3,4, 0,0,0, 0,0,0, 1,1,0, 0,0,0,0);
    tbl[12] = mk(1,1,0,1, 5,9, 1,5,1, 0,0,0, 1,1,0, 1,0,0,0);
    tbl[13] = mk(1,1,0,1, 5,9, 1,5,1, 0,0,0, 1,0,1, 0,0,0,0);
    tbl[14] = mk(1,1,1,1, 3,4, 0,0,0, 0,0,0, 1,0,1, 0,0,0,0);

    // reset state
    @(negedge clk);
    chk("rst_stall", bus.br_stall, 0);
    chk("rst_ds", bus.ds_flag, 0);
    chk("rst_bcnt", bus.branch_cnt, 0);
    chk("rst_tcnt", bus.taken_cnt, 0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // single-cycle decode table from IDLE
    for (int i = 0; i < 15; i++) begin
      do_reset();
      apply(tbl[i]);
      @(negedge clk);
      chk($sformatf("t%0d_stall", i), bus.br_stall, tbl[i].e_stall);
      chk($sformatf("t%0d_redir", i), bus.br_redirect, tbl[i].e_red);
      chk($sformatf("t%0d_link", i), bus.br_link, tbl[i].e_link);
      @(posedge clk); #1;
      apply(z);
      @(negedge clk);
      chk($sformatf("t%0d_ds", i), bus.ds_flag, tbl[i].e_ds);
    end

    // EX load-use: two stall cycles, resolve on the third
    do_reset();
    apply(mk(1,1,0,1, 5,9, 1,5,1, 0,0,0, 1,0,0, 0,0,0,0));
    run_stall(-1, -1, nst, rd);
    chk("lu_nstall", nst, 2);
    chk("lu_redir", rd, 1);
    @(posedge clk); #1;
    apply(z);
    @(negedge clk);
    chk("lu_ds", bus.ds_flag, 1);
    chk("lu_bcnt", bus.branch_cnt, 1);

    // EX ALU on rs plus MEM load on rt: one stall cycle, not taken
    do_reset();
    apply(mk(1,1,0,1, 5,6, 1,5,0, 1,6,1, 0,0,0, 0,0,0,0));
    run_stall(-1, -1, nst, rd);
    chk("alu_nstall", nst, 1);
    chk("alu_redir", rd, 0);
    @(posedge clk); #1;
    apply(z);
    @(negedge clk);
    chk("alu_bcnt", bus.branch_cnt, 1);
    chk("alu_tcnt", bus.taken_cnt, 0);

    // pipe_stall for 3 cycles inside WAIT extends the stall to N+3
    do_reset();
    apply(mk(1,1,0,1, 5,9, 1,5,1, 0,0,0, 1,0,0, 0,0,0,0));
    run_stall(1, 3, nst, rd);
    chk("ps_nstall", nst, 5);
    chk("ps_redir", rd, 1);
    chk("ps_bcnt_pre", bus.branch_cnt, 0);

    // pipe_stall in the resolve cycle holds the redirect until released
    do_reset();
    apply(mk(1,1,0,1, 3,4, 0,0,0, 0,0,0, 1,1,0, 0,0,0,0));
    @(negedge clk);
    chk("psr_redir0", bus.br_redirect, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("psr_redir1", bus.br_redirect, 0);
    chk("psr_ds", bus.ds_flag, 0);
    @(posedge clk); #1;
    pipe_stall = 1'b0;
    @(negedge clk);
    chk("psr_redir2", bus.br_redirect, 1);
    @(posedge clk); #1;
    apply(z);
    @(negedge clk);
    chk("psr_bcnt", bus.branch_cnt, 1);

    // flush in WAIT: outputs drop at once, IDLE next cycle
    do_reset();
    apply(mk(1,1,0,1, 5,9, 1,5,1, 0,0,0, 1,0,0, 0,0,0,0));
    @(negedge clk);
    chk("fw_stall0", bus.br_stall, 1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("fw_stall1", bus.br_stall, 0);
    chk("fw_redir1", bus.br_redirect, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    bus.ex_wreg = 1'b0;
    @(negedge clk);
    chk("fw_stall2", bus.br_stall, 0);
    chk("fw_redir2", bus.br_redirect, 1);
    chk("fw_bcnt", bus.branch_cnt, 0);

    // flush in DSLOT clears ds_flag next cycle
    do_reset();
    apply(mk(1,1,0,1, 3,4, 0,0,0, 0,0,0, 1,0,0, 0,0,0,0));
    @(posedge clk); #1;
    apply(z);
    flush = 1'b1;
    @(negedge clk);
    chk("fd_ds0", bus.ds_flag, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("fd_ds1", bus.ds_flag, 0);
    chk("fd_bcnt", bus.branch_cnt, 1);

    // branch in the delay slot is ignored
    do_reset();
    apply(mk(1,1,1,1, 3,4, 0,0,0, 0,0,0, 1,0,0, 0,0,0,0));
    @(negedge clk);
    chk("dsb_redir0", bus.br_redirect, 1);
    chk("dsb_link0", bus.br_link, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("dsb_ds", bus.ds_flag, 1);
    chk("dsb_redir1", bus.br_redirect, 0);
    chk("dsb_link1", bus.br_link, 0);
    @(posedge clk); #1;
    apply(z);
    @(negedge clk);
    chk("dsb_ds2", bus.ds_flag, 0);
    chk("dsb_bcnt", bus.branch_cnt, 1);
    chk("dsb_tcnt", bus.taken_cnt, 1);

    // saturation: 17 taken branches with 4-bit counters
    do_reset();
    for (int k = 0; k < 17; k++) begin
      apply(mk(1,1,0,1, 3,4, 0,0,0, 0,0,0, 1,0,0, 0,0,0,0));
      @(posedge clk); #1;
      apply(mk(1,0,0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0));
      @(posedge clk); #1;
    end
    apply(z);
    @(negedge clk);
    chk("sat_bcnt", bus.branch_cnt, SAT);
    chk("sat_tcnt", bus.taken_cnt, SAT);
    resetn = 1'b0;
    @(negedge clk);
    chk("sat_rst_bcnt", bus.branch_cnt, 0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // random stimulus against the reference model
    wl = 0; mds = 0; mb = 0; mt = 0;
    for (int c = 0; c < 3000; c++) begin
      r = mk(($urandom_range(9) < 8), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
             5'($urandom_range(3)), 5'($urandom_range(3)),
             1'($urandom_range(1)), 5'($urandom_range(3)), 1'($urandom_range(1)),
             1'($urandom_range(1)), 5'($urandom_range(3)), 1'($urandom_range(1)),
             1'($urandom_range(1)), ($urandom_range(4) == 0), ($urandom_range(29) == 0),
             0,0,0,0);
      apply(r);

      e_ds = mds; e_stall = 0; e_red = 0; e_lk = 0; res = 0;
      if (wl > 0) begin
        e_stall = 1;
        if (!r.ps) wl--;
      end else if (mds) begin
        if (r.v && !r.ps) mds = 0;
      end else if (r.v && r.br) begin
        nr = (r.rs == 0) ? 0 : (r.exw && r.exa == r.rs) ? (r.exl ? 2 : 1) :
             (r.mw && r.ml && r.ma == r.rs) ? 1 : 0;
        nt = (!r.urt || r.rt == 0) ? 0 : (r.exw && r.exa == r.rt) ? (r.exl ? 2 : 1) :
             (r.mw && r.ml && r.ma == r.rt) ? 1 : 0;
        n = (nr > nt) ? nr : nt;
        if (n > 0) begin
          e_stall = 1;
          if (!r.ps) wl = n - 1;
        end else if (!r.ps) begin
          res = 1; e_red = r.cy; e_lk = r.lk; mds = 1;
        end
      end
      if (r.fl) begin
        e_stall = 0; e_red = 0; e_lk = 0; res = 0; wl = 0; mds = 0;
      end

      @(negedge clk);
      chk($sformatf("r%0d_stall", c), bus.br_stall, e_stall);
      chk($sformatf("r%0d_redir", c), bus.br_redirect, e_red);
      chk($sformatf("r%0d_link", c), bus.br_link, e_lk);
      chk($sformatf("r%0d_ds", c), bus.ds_flag, e_ds);
      chk($sformatf("r%0d_bcnt", c), bus.branch_cnt, mb);
      chk($sformatf("r%0d_tcnt", c), bus.taken_cnt, mt);
      if (res) begin
        if (mb < SAT) mb++;
        if (r.cy && mt < SAT) mt++;
      end
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
